// File: rtl/drop_pkg.sv
// Shared widths, FSM encodings and the faulty-sensor averaging rule for drop_time_calc.
package drop_pkg;

    localparam int unsigned SENSOR_W   = 8;
    localparam int unsigned T_W        = 16;
    localparam int unsigned SQRT_ITERS = 12;
    localparam int unsigned RADICAND_W = 24;

    // One root bit per iteration, two radicand bits consumed per iteration.
    localparam int unsigned ROOT_W  = RADICAND_W / 2;
    // Remainder never exceeds 2*root, so two spare bits above the root suffice.
    localparam int unsigned REM_W   = ROOT_W + 2;
    localparam int unsigned ITER_W  = 4;
    localparam int unsigned SUM_W   = 10;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_AVG  = 2'd1;
    localparam logic [STATE_W-1:0] ST_SQRT = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

    // Half-up rounded average; a zero reading on sensor 1/3 outranks one on sensor 2/4.
    function automatic logic [SENSOR_W-1:0] avg_height(
        input logic [SENSOR_W-1:0] s1,
        input logic [SENSOR_W-1:0] s2,
        input logic [SENSOR_W-1:0] s3,
        input logic [SENSOR_W-1:0] s4
    );
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] avg;
        if ((s1 == '0) || (s3 == '0)) begin
            sum = SUM_W'(s2) + SUM_W'(s4) + SUM_W'(1);
            avg = sum >> 1;
        end else if ((s2 == '0) || (s4 == '0)) begin
            sum = SUM_W'(s1) + SUM_W'(s3) + SUM_W'(1);
            avg = sum >> 1;
        end else begin
            sum = SUM_W'(s1) + SUM_W'(s2) + SUM_W'(s3) + SUM_W'(s4) + SUM_W'(2);
            avg = sum >> 2;
        end
        return SENSOR_W'(avg);
    endfunction

endpackage

// File: rtl/isqrt_iter.sv
// One restoring digit-by-digit square-root step: bring in a radicand bit pair,
// try subtracting (4*root + 1), keep the result and set the new root bit if it fits.
module isqrt_iter
    import drop_pkg::*;
(
    input  logic [ROOT_W-1:0] root_i,
    input  logic [REM_W-1:0]  rem_i,
    input  logic [1:0]        pair_i,
    output logic [ROOT_W-1:0] root_o,
    output logic [REM_W-1:0]  rem_o
);

    logic [REM_W+1:0] shifted_c;
    logic [REM_W+1:0] trial_c;
    logic [REM_W+1:0] diff_c;
    logic             fits_c;

    // Trial subtraction and root/remainder update.
    always_comb begin
        shifted_c = {rem_i, pair_i};
        trial_c   = (REM_W + 2)'({root_i, 2'b01});
        diff_c    = shifted_c - trial_c;
        fits_c    = (shifted_c >= trial_c);
        root_o    = {root_i[ROOT_W-2:0], fits_c};
        rem_o     = fits_c ? REM_W'(diff_c) : REM_W'(shifted_c);
    end

endmodule

// File: rtl/drop_time_calc.sv
// Averages one four-sensor altitude packet and computes t_act = sqrt(h) in 8.8
// fixed point with a 12-cycle bit-serial root; qualifies the operator arm request.
module drop_time_calc
    import drop_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SENSOR_W-1:0] sensor1,
    input  logic [SENSOR_W-1:0] sensor2,
    input  logic [SENSOR_W-1:0] sensor3,
    input  logic [SENSOR_W-1:0] sensor4,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                arm,
    output logic [T_W-1:0]      t_act,
    output logic                t_act_valid,
    output logic                drop_en
);

    logic [STATE_W-1:0]    state_q,       state_d;
    logic [SENSOR_W-1:0]   s1_q,          s1_d;
    logic [SENSOR_W-1:0]   s2_q,          s2_d;
    logic [SENSOR_W-1:0]   s3_q,          s3_d;
    logic [SENSOR_W-1:0]   s4_q,          s4_d;
    logic [RADICAND_W-1:0] rad_q,         rad_d;
    logic [ROOT_W-1:0]     root_q,        root_d;
    logic [REM_W-1:0]      rem_q,         rem_d;
    logic [ITER_W-1:0]     iter_q,        iter_d;
    logic [T_W-1:0]        t_act_q,       t_act_d;
    logic                  t_valid_q,     t_valid_d;
    logic                  ready_q,       ready_d;
    logic                  seen_q,        seen_d;
    logic                  drop_en_q,     drop_en_d;

    logic [ROOT_W-1:0]     root_next_c;
    logic [REM_W-1:0]      rem_next_c;
    logic [SENSOR_W-1:0]   h_c;

    // Single root step fed by the top radicand bit pair.
    isqrt_iter u_step (
        .root_i (root_q),
        .rem_i  (rem_q),
        .pair_i (rad_q[RADICAND_W-1 -: 2]),
        .root_o (root_next_c),
        .rem_o  (rem_next_c)
    );

    assign h_c = avg_height(s1_q, s2_q, s3_q, s4_q);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        s3_d      = s3_q;
        s4_d      = s4_q;
        rad_d     = rad_q;
        root_d    = root_q;
        rem_d     = rem_q;
        iter_d    = iter_q;
        t_act_d   = t_act_q;
        t_valid_d = 1'b0;
        seen_d    = seen_q;
        drop_en_d = arm && seen_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    s1_d    = sensor1;
                    s2_d    = sensor2;
                    s3_d    = sensor3;
                    s4_d    = sensor4;
                    state_d = ST_AVG;
                end
            end
            ST_AVG: begin
                rad_d   = {h_c, {(RADICAND_W - SENSOR_W){1'b0}}};
                root_d  = '0;
                rem_d   = '0;
                iter_d  = '0;
                state_d = ST_SQRT;
            end
            ST_SQRT: begin
                root_d = root_next_c;
                rem_d  = rem_next_c;
                rad_d  = {rad_q[RADICAND_W-3:0], 2'b00};
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(SQRT_ITERS - 1)) begin
                    t_act_d   = T_W'(root_next_c);
                    t_valid_d = 1'b1;
                    seen_d    = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            s4_q      <= '0;
            rad_q     <= '0;
            root_q    <= '0;
            rem_q     <= '0;
            iter_q    <= '0;
            t_act_q   <= '0;
            t_valid_q <= 1'b0;
            ready_q   <= 1'b1;
            seen_q    <= 1'b0;
            drop_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            s4_q      <= s4_d;
            rad_q     <= rad_d;
            root_q    <= root_d;
            rem_q     <= rem_d;
            iter_q    <= iter_d;
            t_act_q   <= t_act_d;
            t_valid_q <= t_valid_d;
            ready_q   <= ready_d;
            seen_q    <= seen_d;
            drop_en_q <= drop_en_d;
        end
    end

    assign sample_ready = ready_q;
    assign t_act        = t_act_q;
    assign t_act_valid  = t_valid_q;
    assign drop_en      = drop_en_q;

endmodule

// File: tb/tb_drop_time_calc.sv
// Directed bench for drop_time_calc: hand-computed drop times, handshake timing,
// arm qualification and mid-computation reset.
module tb_drop_time_calc;

    logic        clk;
    logic        rst;
    logic [7:0]  sensor1, sensor2, sensor3, sensor4;
    logic        sample_valid;
    logic        sample_ready;
    logic        arm;
    logic [15:0] t_act;
    logic        t_act_valid;
    logic        drop_en;

    int n_checks = 0;
    int n_fail   = 0;

    drop_time_calc dut (
        .clk          (clk),
        .rst          (rst),
        .sensor1      (sensor1),
        .sensor2      (sensor2),
        .sensor3      (sensor3),
        .sensor4      (sensor4),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .arm          (arm),
        .t_act        (t_act),
        .t_act_valid  (t_act_valid),
        .drop_en      (drop_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sensors(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
        sensor1 = a;
        sensor2 = b;
        sensor3 = c;
        sensor4 = d;
    endtask

    // Full packet: handshake at edge k, result expected on edge k+13, idle after k+14.
    // glitch != 0 pulses sample_valid (with different data) before edge k+glitch.
    task automatic run_packet(input string name,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d,
                              input logic [15:0] exp_t,
                              input logic de13, input logic de14,
                              input int glitch);
        logic [15:0] prev;
        prev = t_act;
        chk({name, "_ready_pre"}, 16'(sample_ready), 16'd1);
        set_sensors(a, b, c, d);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk({name, "_ready_busy"}, 16'(sample_ready), 16'd0);
        for (int i = 1; i <= 12; i++) begin
            if (i == glitch) begin
                set_sensors(8'd255, 8'd255, 8'd255, 8'd255);
                sample_valid = 1'b1;
            end
            step();
            sample_valid = 1'b0;
            chk({name, "_hold_t"}, t_act, prev);
            chk({name, "_no_valid"}, 16'(t_act_valid), 16'd0);
            chk({name, "_busy"}, 16'(sample_ready), 16'd0);
        end
        step();
        chk({name, "_valid"}, 16'(t_act_valid), 16'd1);
        chk({name, "_t_act"}, t_act, exp_t);
        chk({name, "_de13"}, 16'(drop_en), 16'(de13));
        step();
        chk({name, "_valid_end"}, 16'(t_act_valid), 16'd0);
        chk({name, "_ready_post"}, 16'(sample_ready), 16'd1);
        chk({name, "_t_keep"}, t_act, exp_t);
        chk({name, "_de14"}, 16'(drop_en), 16'(de14));
    endtask

    initial begin
        rst          = 1'b1;
        arm          = 1'b1;
        sample_valid = 1'b0;
        set_sensors(8'd0, 8'd0, 8'd0, 8'd0);
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 16'(sample_ready), 16'd1);
        chk("rst_t_act", t_act, 16'h0000);
        chk("rst_valid", 16'(t_act_valid), 16'd0);
        chk("rst_drop_en", 16'(drop_en), 16'd0);
        step();
        chk("arm_no_result", 16'(drop_en), 16'd0);

        // h=100 -> 10.0; first result so drop_en rises one edge after the load.
        run_packet("all100", 8'd100, 8'd100, 8'd100, 8'd100, 16'h0A00, 1'b0, 1'b1, 0);

        // Sensor1 zero -> (64+64+1)>>1 = 64 -> 8.0; a valid pulse mid-SQRT is ignored.
        run_packet("s1zero", 8'd0, 8'd64, 8'd200, 8'd64, 16'h0800, 1'b1, 1'b1, 5);
        step();
        chk("glitch_idle", 16'(sample_ready), 16'd1);
        chk("glitch_t", t_act, 16'h0800);

        // Sensor2 zero -> (36+36+1)>>1 = 36 -> 6.0.
        run_packet("s2zero", 8'd36, 8'd0, 8'd36, 8'd50, 16'h0600, 1'b1, 1'b1, 0);

        // Sum 7 -> (7+2)>>2 = 2 -> floor(sqrt(2*65536)) = 362.
        run_packet("h2", 8'd1, 8'd2, 8'd2, 8'd2, 16'h016A, 1'b1, 1'b1, 0);

        // h=255 -> floor(sqrt(255*65536)) = 4087.
        run_packet("h255", 8'd255, 8'd255, 8'd255, 8'd255, 16'h0FF7, 1'b1, 1'b1, 0);
        chk("h255_top_nibble", 16'(t_act[15:12]), 16'd0);

        // Back-to-back with valid held high: second packet accepted on edge k+15.
        set_sensors(8'd100, 8'd100, 8'd100, 8'd100);
        sample_valid = 1'b1;
        step();
        set_sensors(8'd64, 8'd64, 8'd64, 8'd64);
        for (int i = 1; i <= 12; i++) step();
        chk("b2b_busy_k12", 16'(sample_ready), 16'd0);
        step();
        chk("b2b_first_valid", 16'(t_act_valid), 16'd1);
        chk("b2b_first_t", t_act, 16'h0A00);
        step();
        chk("b2b_ready_k14", 16'(sample_ready), 16'd1);
        step();
        sample_valid = 1'b0;
        chk("b2b_accept_k15", 16'(sample_ready), 16'd0);
        for (int i = 1; i <= 12; i++) step();
        chk("b2b_second_pending", 16'(t_act_valid), 16'd0);
        step();
        chk("b2b_second_valid", 16'(t_act_valid), 16'd1);
        chk("b2b_second_t", t_act, 16'h0800);
        step();
        chk("b2b_idle", 16'(sample_ready), 16'd1);

        // arm deassert/reassert: drop_en follows one edge later.
        arm = 1'b0;
        step();
        chk("arm_off", 16'(drop_en), 16'd0);
        arm = 1'b1;
        step();
        chk("arm_on", 16'(drop_en), 16'd1);

        // Reset sampled on edge k+7 of a computation.
        set_sensors(8'd100, 8'd100, 8'd100, 8'd100);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        for (int i = 1; i <= 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_t_act", t_act, 16'h0000);
        chk("midrst_valid", 16'(t_act_valid), 16'd0);
        chk("midrst_drop_en", 16'(drop_en), 16'd0);
        chk("midrst_ready", 16'(sample_ready), 16'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("midrst_no_pulse", 16'(t_act_valid), 16'd0);
        end
        chk("midrst_arm_blocked", 16'(drop_en), 16'd0);

        // Fresh computation after the abort; result_seen was cleared.
        run_packet("after_rst", 8'd1, 8'd2, 8'd2, 8'd2, 16'h016A, 1'b0, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
